// File: rtl/ahb_chk_pkg.sv
// AHB-Lite checker shared types: transfer/burst encodings, violation codes,
// checker FSM states and the beat-count / next-address helpers.
package ahb_chk_pkg;

  localparam int NUM_CHK = 8;

  typedef enum logic [1:0] {
    TR_IDLE, TR_BUSY, TR_NONSEQ, TR_SEQ
  } htrans_e;

  typedef enum logic [2:0] {
    HB_SINGLE, HB_INCR, HB_WRAP4, HB_INCR4,
    HB_WRAP8, HB_INCR8, HB_WRAP16, HB_INCR16
  } hburst_e;

  typedef enum logic [3:0] {
    E_NONE, E_SEQ_NO_BURST, E_ADDR_MISMATCH,
    E_CTRL_CHANGE, E_EARLY_TERM, E_WAIT_TIMEOUT,
    E_KB_CROSS, E_RESP_ONECYC, E_RESP_DROP
  } err_code_e;

  typedef enum logic [1:0] {
    S_IDLE, S_BURST, S_ERRRESP
  } chk_state_e;

  function automatic logic [4:0] burst_beats(
    hburst_e b
  );
    case (b)
      HB_WRAP4, HB_INCR4:   return 5'd4;
      HB_WRAP8, HB_INCR8:   return 5'd8;
      HB_WRAP16, HB_INCR16: return 5'd16;
      default:              return 5'd0;
    endcase
  endfunction

  function automatic logic is_wrap(
    hburst_e b
  );
    return (b == HB_WRAP4) || (b == HB_WRAP8) ||
           (b == HB_WRAP16);
  endfunction

  // 64-bit working width; callers zero-extend and truncate
  function automatic logic [63:0] next_addr(
    logic [63:0] addr,
    logic [2:0]  hsize,
    hburst_e     hburst
  );
    logic [63:0] incr, nxt, mask;
    incr = 64'd1 << hsize;
    nxt  = addr + incr;
    if (is_wrap(hburst)) begin
      mask = (64'(burst_beats(hburst)) * incr) - 64'd1;
      nxt  = (addr & ~mask) | (nxt & mask);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/ahb_protocol_checker_if.sv
// AHB-Lite link bundle with manager, subordinate and passive-tap views.
interface ahb_protocol_checker_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] haddr;
  logic [2:0]        hburst;
  logic [2:0]        hsize;
  logic [1:0]        htrans;
  logic              hwrite;
  logic              hreadyout;
  logic [1:0]        hresp;

  modport master (
    output haddr, hburst, hsize, htrans, hwrite,
    input  hreadyout, hresp
  );

  modport slave (
    input  haddr, hburst, hsize, htrans, hwrite,
    output hreadyout, hresp
  );

  modport monitor (
    input haddr, hburst, hsize, htrans, hwrite,
    input hreadyout, hresp
  );
endinterface

// File: rtl/ahb_chk_wait_timer.sv
// Saturating count of consecutive hreadyout-low cycles; tmo marks the
// cycle that pushes the count past MAX_WAIT (once per data phase).
module ahb_chk_wait_timer #(
  parameter int MAX_WAIT = 16
) (
  input  logic hclk,
  input  logic hrst,
  input  logic hreadyout,
  output logic tmo
);
  localparam int CW = $clog2(MAX_WAIT + 2);
  localparam logic [CW-1:0] LIM = CW'(MAX_WAIT);
  localparam logic [CW-1:0] SAT = CW'(MAX_WAIT + 1);

  logic [CW-1:0] cnt;

  assign tmo = !hreadyout && (cnt == LIM);

  always_ff @(posedge hclk) begin
    if (!hrst)
      cnt <= '0;
    else if (hreadyout)
      cnt <= '0;
    else if (cnt != SAT)
      cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/ahb_protocol_checker.sv
// Passive AHB-Lite protocol checker with coded violation pulses.
// Define AHB_CHK_STATS_EN to add transfer/wait/burst statistics outputs.
module ahb_protocol_checker
  import ahb_chk_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic               hclk,
  input  logic               hrst,
  ahb_protocol_checker_if.monitor bus,
  input  logic               err_clr,
  output logic               err_valid,
  output logic [3:0]         err_code,
  output logic [ADDR_W-1:0]  err_addr,
  output logic [NUM_CHK-1:0] err_sticky,
  output logic [4:0]         beats_left
`ifdef AHB_CHK_STATS_EN
  ,
  output logic [31:0]        xfer_cnt,
  output logic [31:0]        wait_cnt,
  output logic [15:0]        burst_cnt
`endif
);
  chk_state_e        st, st_n;
  hburst_e           l_burst;
  logic [2:0]        l_size;
  logic              l_write;
  logic [ADDR_W-1:0] l_addr;
  logic [4:0]        bl_n;
  logic              ld, la, tmo;
  logic [NUM_CHK-1:0] viol;
  err_code_e         code;
  logic [63:0]       la64, na64;
  logic [ADDR_W-1:0] exp_addr;

  htrans_e tr;
  hburst_e hb;
  logic    acc, is_seq, is_ns, term, fixed, err_ent;

  assign tr      = htrans_e'(bus.htrans);
  assign hb      = hburst_e'(bus.hburst);
  assign acc     = bus.htrans[1] & bus.hreadyout;
  assign is_seq  = acc && (tr == TR_SEQ);
  assign is_ns   = acc && (tr == TR_NONSEQ);
  assign term    = bus.hreadyout &&
                   (tr == TR_IDLE || tr == TR_NONSEQ);
  assign fixed   = (l_burst != HB_INCR);
  assign err_ent = bus.hresp[0] & ~bus.hreadyout;

  always_comb begin
    la64 = '0;
    la64[ADDR_W-1:0] = l_addr;
  end
  assign na64     = next_addr(la64, l_size, l_burst);
  assign exp_addr = na64[ADDR_W-1:0];

  ahb_chk_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait (
    .hclk      (hclk),
    .hrst      (hrst),
    .hreadyout (bus.hreadyout),
    .tmo       (tmo)
  );

  always_comb begin
    viol = '0;
    viol[0] = (st == S_IDLE) &&
              (tr == TR_SEQ || tr == TR_BUSY);
    if (st == S_BURST && is_seq) begin
      viol[1] = bus.haddr != exp_addr;
      viol[2] = (hb != l_burst) ||
                (bus.hsize != l_size) ||
                (bus.hwrite != l_write);
      viol[5] = (l_burst == HB_INCR) &&
                (bus.haddr[ADDR_W-1:10] !=
                 l_addr[ADDR_W-1:10]);
    end
    viol[3] = (st == S_BURST) && term && fixed &&
              (beats_left != 5'd0);
    viol[4] = tmo;
    viol[6] = bus.hresp[0] && bus.hreadyout &&
              (st != S_ERRRESP);
    viol[7] = (st == S_ERRRESP) && !bus.hresp[0];
  end

  // lowest active code wins the report
  always_comb begin
    code = E_NONE;
    for (int i = NUM_CHK - 1; i >= 0; i--)
      if (viol[i]) code = err_code_e'(4'(i + 1));
  end

  always_comb begin
    st_n = st;
    bl_n = beats_left;
    ld   = 1'b0;
    la   = 1'b0;
    unique case (st)
      S_IDLE: begin
        if (is_ns && hb != HB_SINGLE) begin
          st_n = S_BURST;
          ld   = 1'b1;
        end
      end
      S_BURST: begin
        if (is_seq) begin
          la = 1'b1;
          if (fixed) begin
            bl_n = beats_left - 5'd1;
            if (beats_left == 5'd1) st_n = S_IDLE;
          end
        end else if (term) begin
          st_n = S_IDLE;
          bl_n = 5'd0;
          if (is_ns && hb != HB_SINGLE) begin
            st_n = S_BURST;
            ld   = 1'b1;
          end
        end
      end
      S_ERRRESP: st_n = S_IDLE;
      default:   st_n = S_IDLE;
    endcase
    if (ld)
      bl_n = (burst_beats(hb) == 5'd0) ? 5'd0 :
             burst_beats(hb) - 5'd1;
    if (err_ent && st != S_ERRRESP) begin
      st_n = S_ERRRESP;
      bl_n = 5'd0;
      ld   = 1'b0;
      la   = 1'b0;
    end
  end

  always_ff @(posedge hclk) begin
    if (!hrst) begin
      st         <= S_IDLE;
      beats_left <= '0;
      l_burst    <= HB_SINGLE;
      l_size     <= '0;
      l_write    <= 1'b0;
      l_addr     <= '0;
      err_valid  <= 1'b0;
      err_code   <= '0;
      err_addr   <= '0;
      err_sticky <= '0;
    end else begin
      st         <= st_n;
      beats_left <= bl_n;
      if (ld) begin
        l_burst <= hb;
        l_size  <= bus.hsize;
        l_write <= bus.hwrite;
      end
      if (ld || la) l_addr <= bus.haddr;
      err_valid  <= |viol;
      err_code   <= code;
      err_addr   <= (|viol) ? bus.haddr : '0;
      err_sticky <= (err_clr ? '0 : err_sticky) | viol;
    end
  end

`ifdef AHB_CHK_STATS_EN
  logic done;
  assign done = (st == S_BURST) &&
                !(err_ent) &&
                ((is_seq && fixed && beats_left == 5'd1) ||
                 (term && !fixed));

  always_ff @(posedge hclk) begin
    if (!hrst || err_clr) begin
      xfer_cnt  <= '0;
      wait_cnt  <= '0;
      burst_cnt <= '0;
    end else begin
      if (acc)            xfer_cnt  <= xfer_cnt + 32'd1;
      if (!bus.hreadyout) wait_cnt  <= wait_cnt + 32'd1;
      if (done)           burst_cnt <= burst_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ahb_protocol_checker.sv
// Directed bench for ahb_protocol_checker: stimulus pushes expected
// violations into a queue, a negedge monitor pops and compares pulses.
module tb_ahb_protocol_checker;
  logic        hclk = 1'b0;
  logic        hrst = 1'b0;
  logic        err_clr = 1'b0;
  logic        err_valid;
  logic [3:0]  err_code;
  logic [31:0] err_addr;
  logic [7:0]  err_sticky;
  logic [4:0]  beats_left;
`ifdef AHB_CHK_STATS_EN
  logic [31:0] xfer_cnt, wait_cnt;
  logic [15:0] burst_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0]  code;
    logic [31:0] addr;
  } exp_t;
  exp_t q[$];

  ahb_protocol_checker_if #(.ADDR_W(32)) bus ();

  ahb_protocol_checker #(.ADDR_W(32), .MAX_WAIT(4)) dut (
    .hclk       (hclk),
    .hrst       (hrst),
    .bus        (bus),
    .err_clr    (err_clr),
    .err_valid  (err_valid),
    .err_code   (err_code),
    .err_addr   (err_addr),
    .err_sticky (err_sticky),
    .beats_left (beats_left)
`ifdef AHB_CHK_STATS_EN
    ,
    .xfer_cnt   (xfer_cnt),
    .wait_cnt   (wait_cnt),
    .burst_cnt  (burst_cnt)
`endif
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] c,
                      input logic [31:0] a);
    exp_t e;
    e.code = c;
    e.addr = a;
    q.push_back(e);
  endtask

  task automatic cyc(input logic [1:0] t,
                     input logic [31:0] a,
                     input logic [2:0] b,
                     input logic [2:0] s,
                     input logic rdy,
                     input logic [1:0] rsp);
    bus.htrans    = t;
    bus.haddr     = a;
    bus.hburst    = b;
    bus.hsize     = s;
    bus.hwrite    = 1'b0;
    bus.hreadyout = rdy;
    bus.hresp     = rsp;
    @(posedge hclk);
    #1;
  endtask

  task automatic tr(input logic [1:0] t,
                    input logic [31:0] a,
                    input logic [2:0] b,
                    input logic [2:0] s);
    cyc(t, a, b, s, 1'b1, 2'd0);
  endtask

  task automatic idl();
    cyc(2'd0, 32'h0, 3'd0, 3'd0, 1'b1, 2'd0);
  endtask

  // monitor: every pulse must match the oldest expected violation
  always @(negedge hclk) begin
    if (err_valid === 1'b1) begin
      n_chk++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: code %0d addr %h, none expected",
                 err_code, err_addr);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (err_code !== e.code || err_addr !== e.addr) begin
          n_fail++;
          $display("FAIL pulse: got code %0d addr %h expected code %0d addr %h",
                   err_code, err_addr, e.code, e.addr);
        end
      end
    end
  end

  localparam logic [1:0] IDLE = 2'd0, NSEQ = 2'd2, SEQ = 2'd3;
  localparam logic [2:0] SGL = 3'd0, INC = 3'd1, W4 = 3'd2;
  localparam logic [2:0] I4 = 3'd3, I8 = 3'd5;

  initial begin
    hrst = 1'b0;
    idl();
    idl();
    chk("rst_valid", 32'(err_valid), 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
    chk("rst_addr", err_addr, 32'd0);
    chk("rst_sticky", 32'(err_sticky), 32'd0);
    chk("rst_beats", 32'(beats_left), 32'd0);
`ifdef AHB_CHK_STATS_EN
    chk("rst_xfer", xfer_cnt, 32'd0);
`endif
    hrst = 1'b1;
    idl();

    // clean INCR4 word burst
    tr(NSEQ, 32'h100, I4, 3'd2);
    chk("incr4_b0", 32'(beats_left), 32'd3);
    tr(SEQ, 32'h104, I4, 3'd2);
    chk("incr4_b1", 32'(beats_left), 32'd2);
    tr(SEQ, 32'h108, I4, 3'd2);
    chk("incr4_b2", 32'(beats_left), 32'd1);
    tr(SEQ, 32'h10C, I4, 3'd2);
    chk("incr4_b3", 32'(beats_left), 32'd0);
    idl();

    // WRAP4 from 0x38: 0x3C good, 0x40 instead of 0x30
    tr(NSEQ, 32'h38, W4, 3'd2);
    tr(SEQ, 32'h3C, W4, 3'd2);
    chk("wrap4_b1", 32'(beats_left), 32'd2);
    push(4'd2, 32'h40);
    tr(SEQ, 32'h40, W4, 3'd2);
    chk("wrap_sticky1", 32'(err_sticky[1]), 32'd1);
    push(4'd4, 32'h0);
    idl();

    // four low cycles: within limit; six low: one timeout
    repeat (4) cyc(IDLE, 32'h0, SGL, 3'd0, 1'b0, 2'd0);
    idl();
    push(4'd5, 32'h0);
    repeat (6) cyc(IDLE, 32'h0, SGL, 3'd0, 1'b0, 2'd0);
    idl();

    // INCR8 cut short by NONSEQ after three beats
    tr(NSEQ, 32'h400, I8, 3'd2);
    tr(SEQ, 32'h404, I8, 3'd2);
    tr(SEQ, 32'h408, I8, 3'd2);
    chk("incr8_b2", 32'(beats_left), 32'd5);
    push(4'd4, 32'h500);
    tr(NSEQ, 32'h500, SGL, 3'd2);
    idl();

    // same cut, preceded by a two-cycle ERROR response
    tr(NSEQ, 32'h400, I8, 3'd2);
    tr(SEQ, 32'h404, I8, 3'd2);
    tr(SEQ, 32'h408, I8, 3'd2);
    cyc(IDLE, 32'h0, SGL, 3'd0, 1'b0, 2'd1);
    cyc(IDLE, 32'h0, SGL, 3'd0, 1'b1, 2'd1);
    tr(NSEQ, 32'h500, SGL, 3'd2);
    idl();

    // single-cycle ERROR, then ERROR dropped after first cycle
    push(4'd7, 32'h0);
    cyc(IDLE, 32'h0, SGL, 3'd0, 1'b1, 2'd1);
    cyc(IDLE, 32'h0, SGL, 3'd0, 1'b0, 2'd1);
    push(4'd8, 32'h0);
    idl();
    idl();

    // simultaneous address + control violation
    err_clr = 1'b1;
    idl();
    err_clr = 1'b0;
    chk("clr_sticky", 32'(err_sticky), 32'd0);
    tr(NSEQ, 32'h200, I4, 3'd2);
    push(4'd2, 32'h208);
    tr(SEQ, 32'h208, I4, 3'd1);
    chk("dual_sticky", 32'(err_sticky), 32'h06);
    tr(SEQ, 32'h20C, I4, 3'd2);
    tr(SEQ, 32'h210, I4, 3'd2);
    chk("dual_end", 32'(beats_left), 32'd0);
    // clear with a fresh violation in the same cycle
    err_clr = 1'b1;
    push(4'd1, 32'h300);
    tr(SEQ, 32'h300, I4, 3'd2);
    err_clr = 1'b0;
    chk("clr_race", 32'(err_sticky), 32'h01);
    err_clr = 1'b1;
    idl();
    err_clr = 1'b0;
    chk("clr_again", 32'(err_sticky), 32'd0);

    // INCR crossing a 1KB boundary
    tr(NSEQ, 32'h3F8, INC, 3'd2);
    chk("incr_beats", 32'(beats_left), 32'd0);
    tr(SEQ, 32'h3FC, INC, 3'd2);
    push(4'd6, 32'h400);
    tr(SEQ, 32'h400, INC, 3'd2);
    chk("kb_sticky", 32'(err_sticky), 32'h20);
    idl();

    // reset mid-burst, SEQ afterwards
    tr(NSEQ, 32'h600, I8, 3'd2);
    tr(SEQ, 32'h604, I8, 3'd2);
    chk("pre_rst_beats", 32'(beats_left), 32'd6);
    hrst = 1'b0;
    tr(SEQ, 32'h608, I8, 3'd2);
    chk("mid_rst_beats", 32'(beats_left), 32'd0);
    chk("mid_rst_valid", 32'(err_valid), 32'd0);
    chk("mid_rst_sticky", 32'(err_sticky), 32'd0);
`ifdef AHB_CHK_STATS_EN
    chk("mid_rst_xfer", xfer_cnt, 32'd0);
`endif
    hrst = 1'b1;
    push(4'd1, 32'h608);
    tr(SEQ, 32'h608, I8, 3'd2);
`ifdef AHB_CHK_STATS_EN
    chk("post_rst_xfer", xfer_cnt, 32'd1);
`endif
    repeat (3) idl();

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ahb_protocol_checker.md
Name: ahb_protocol_checker

Overview:
- Synthesizable, parametrised AHB-Lite protocol checker; passive tap on one manager–subordinate link, beside the interconnect in the bench top and usable in emulation.
- Replaces property-only checks with RTL burst tracking, a wait-state timeout, address-sequence checking and error-response checking.
- Reports each violation as a coded one-cycle pulse and records it in a sticky status vector.

Parameters:
- ADDR_W, 32, haddr width
- MAX_WAIT, 16, max consecutive hreadyout-low cycles allowed in one data phase (1..255)
- NUM_CHK, 8, number of sticky check bits (fixed by package, not overridable below 8)

Ports:
- hclk  in  1  clock
- hrst  in  1  synchronous, active-low reset
- haddr  in  ADDR_W  address
- hburst  in  3  burst type
- hsize  in  3  transfer size
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- hwrite  in  1  direction
- hreadyout  in  1  subordinate ready; also used as hready
- hresp  in  2  bit0 = ERROR
- err_clr  in  1  clears err_sticky
- err_valid  out  1  violation pulse
- err_code  out  4  code of reported violation
- err_addr  out  ADDR_W  haddr of offending cycle
- err_sticky  out  NUM_CHK  one bit per code 1..8 (bit code-1)
- beats_left  out  5  remaining beats of a fixed-length burst

Behaviour:
- Reset (hrst==0 at posedge): all outputs 0, FSM IDLE, wait counter 0.
- Address phase is accepted when htrans[1]==1 and hreadyout==1 at posedge.
- FSM states:
  - IDLE: accepted NONSEQ with hburst==SINGLE stays IDLE. Any other burst → BURST; latch hburst, hsize, hwrite and haddr; beats_left = 4/8/16 minus 1; INCR loads 0 (undefined length).
  - BURST: each accepted SEQ decrements beats_left. Return to IDLE when a fixed burst reaches 0, or on IDLE/NONSEQ for INCR (a new NONSEQ re-enters BURST if non-SINGLE).
  - ERRRESP: entered on hresp[0]==1 with hreadyout==0. Exits to IDLE next cycle.
- Expected next address:
  - incr = 1<<hsize.
  - INCRx: addr+incr.
  - WRAPx: bound = beats*incr; next = (addr & ~(bound-1)) | ((addr+incr) & (bound-1)).
- Checks, all sampled at posedge while hrst==1:
  - 1 SEQ_NO_BURST: SEQ or BUSY sampled in IDLE.
  - 2 ADDR_MISMATCH: accepted SEQ with haddr != expected.
  - 3 CTRL_CHANGE: accepted SEQ with hburst, hsize or hwrite != latched values.
  - 4 EARLY_TERM: IDLE/NONSEQ accepted in BURST with beats_left!=0 on a fixed burst. Suppressed in ERRRESP or the cycle after it.
  - 5 WAIT_TIMEOUT: consecutive hreadyout==0 count reaches MAX_WAIT+1. Counter saturates; flags once per data phase.
  - 6 KB_CROSS: accepted SEQ of an INCR burst whose haddr[ADDR_W-1:10] differs from the previous beat's.
  - 7 RESP_ONECYC: hresp[0]==1 with hreadyout==1 while not in ERRRESP.
  - 8 RESP_DROP: in ERRRESP, hresp[0]==0.
- Reporting:
  - Registered, visible the cycle after the offending edge.
  - On simultaneous violations: every sticky bit is set; err_code reports the lowest code.
  - err_clr clears err_sticky. A new violation in the same cycle wins (its bit is set).
- Reset mid-burst: FSM aborts to IDLE, no violation reported.

Optional Feature:
- AHB_CHK_STATS_EN
  - Defined: adds outputs xfer_cnt[31:0] (accepted NONSEQ+SEQ), wait_cnt[31:0] (hreadyout-low cycles) and burst_cnt[15:0] (completed bursts). All wrap at full scale, reset to 0, and are cleared by err_clr.
  - Undefined: ports and logic absent; checker behaviour identical.

Decomposition:
- Package ahb_chk_pkg holds:
  - htrans_e, hburst_e and err_code_e enums
  - chk_state_e (IDLE, BURST, ERRRESP)
  - function burst_beats(hburst)
  - function next_addr(addr, hsize, hburst)
- One sub-module, ahb_chk_wait_timer: saturating wait counter with timeout pulse.

Test Plan:
- INCR4 word at 0x100 (0x100, 0x104, 0x108, 0x10C), zero waits → no err_valid; beats_left 3,2,1,0.
- WRAP4 word starting 0x38 → expected 0x3C, 0x30, 0x34. Drive 0x40 on beat 2 → err_code=2, err_addr=0x40, err_sticky[1]=1.
- MAX_WAIT=4, hold hreadyout low 5 cycles → single err_code=5 pulse.
- Fixed-burst resp checks:
  - INCR8 interrupted by NONSEQ after beat 3 → err_code=4.
  - Same interruption preceded by a two-cycle ERROR response → no error.
  - Single-cycle ERROR → err_code=7.
- Simultaneous checks: SEQ with haddr wrong and hsize changed → err_code=2; err_sticky bits 1 and 2 set. Then err_clr → sticky 0.
- Reset mid-burst, then SEQ after reset → err_code=1. With AHB_CHK_STATS_EN, xfer_cnt=0 after reset.
